alu16b: RTL and testbench

16-bit combinational ALU with optional output register, used as the execute-stage arithmetic/logic unit of the pipelined processor. Per-operand negate/invert controls feed a shared datapath implementing shifts, rotates, add, logic ops, bit reversal and byte packing. Zero, greater-than-zero and carry flags accompany every result.

---
 rtl/alu16b.sv | 96 +++++++++
 tb/tb_alu16b.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu16b.sv
// 16-bit execute-stage ALU with per-operand negate/invert conditioning and Z/GZ/C flags.
// Define ALU_OUT_REG_EN to register all outputs (1-cycle latency, async active-low rst).
module alu16b (
    output logic [15:0] out,
    output logic        cOut,
    output logic        zero,
    output logic        gZero,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [3:0]  op,
    input  logic        neg1,
    input  logic        neg2,
    input  logic        clk,
    input  logic        rst
);

    logic [15:0] opa;
    logic [15:0] opb;
    logic [4:0]  shamt;
    logic [4:0]  shamt_inv;
    logic [15:0] rev_a;
    logic [15:0] result_d;
    logic        carry_d;
    logic        zero_d;
    logic        gzero_d;

    assign opa       = neg1 ? (~in1 + 16'd1) : in1;
    assign opb       = neg2 ? ~in2 : in2;
    assign shamt     = {1'b0, opb[3:0]};
    // A shift by 16 (when shamt is 0) yields zero, so rotates by 0 return A unchanged.
    assign shamt_inv = 5'd16 - shamt;

    always_comb begin
        rev_a = '0;
        for (int i = 0; i < 16; i++) begin
            rev_a[i] = opa[15-i];
        end
    end

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        casez (op)
            4'b0000: result_d = opa << shamt;
            4'b0001: result_d = opa >> shamt;
            4'b0010: result_d = (opa << shamt) | (opa >> shamt_inv);
            4'b0011: result_d = (opa >> shamt) | (opa << shamt_inv);
            4'b0100: {carry_d, result_d} = {1'b0, opa} + {1'b0, opb};
            4'b0101: result_d = opa & opb;
            4'b0110: result_d = opa ^ opb;
            4'b0111: result_d = opa | opb;
            4'b10??: result_d = rev_a;
            4'b11??: result_d = {opa[7:0], opb[7:0]};
            default: result_d = '0;
        endcase
    end

    assign zero_d  = (result_d == 16'h0000);
    assign gzero_d = ~result_d[15] & ~zero_d;

`ifdef ALU_OUT_REG_EN
    logic [15:0] out_q;
    logic        cout_q;
    logic        zero_q;
    logic        gzero_q;

    // Reset value reflects out=0, so zero is 1 while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= 16'h0000;
            cout_q  <= 1'b0;
            zero_q  <= 1'b1;
            gzero_q <= 1'b0;
        end else begin
            out_q   <= result_d;
            cout_q  <= carry_d;
            zero_q  <= zero_d;
            gzero_q <= gzero_d;
        end
    end

    assign out   = out_q;
    assign cOut  = cout_q;
    assign zero  = zero_q;
    assign gZero = gzero_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    assign out   = result_d;
    assign cOut  = carry_d;
    assign zero  = zero_d;
    assign gZero = gzero_d;
`endif

endmodule

// File: tb/tb_alu16b.sv
// Self-checking bench for alu16b: directed vectors, randomized sweep vs. a behavioural
// model, and (with ALU_OUT_REG_EN) async reset and 1-cycle latency checks.
module tb_alu16b;

    logic        clk;
    logic        rst;
    logic [15:0] out;
    logic        cOut;
    logic        zero;
    logic        gZero;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [3:0]  op;
    logic        neg1;
    logic        neg2;

    int n_cmp = 0;
    int n_err = 0;

    alu16b dut (
        .out   (out),
        .cOut  (cOut),
        .zero  (zero),
        .gZero (gZero),
        .in1   (in1),
        .in2   (in2),
        .op    (op),
        .neg1  (neg1),
        .neg2  (neg2),
        .clk   (clk),
        .rst   (rst)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {carry, result}, computed with plain integer arithmetic.
    function automatic logic [16:0] model(input logic [15:0] x1, input logic [15:0] x2,
                                          input logic [3:0] o, input logic n1, input logic n2);
        int a;
        int b;
        int s;
        int sum;
        logic [31:0] t;
        logic [15:0] av;
        logic [15:0] r;
        a = n1 ? (65536 - int'(x1)) % 65536 : int'(x1);
        b = n2 ? 65535 - int'(x2) : int'(x2);
        s = b % 16;
        av = 16'(a);
        r = '0;
        if (o == 4'd0) r = 16'(a << s);
        else if (o == 4'd1) r = 16'(a >> s);
        else if (o == 4'd2) begin
            t = {av, av} << s;
            r = t[31:16];
        end else if (o == 4'd3) begin
            t = {av, av} >> s;
            r = t[15:0];
        end else if (o == 4'd4) begin
            sum = a + b;
            return {(sum >= 65536) ? 1'b1 : 1'b0, 16'(sum)};
        end else if (o == 4'd5) r = 16'(a & b);
        else if (o == 4'd6) r = 16'(a ^ b);
        else if (o == 4'd7) r = 16'(a | b);
        else if (o < 4'd12) begin
            for (int i = 0; i < 16; i++) r[15-i] = av[i];
        end else r = 16'((a % 256) * 256 + (b % 256));
        return {1'b0, r};
    endfunction

    // ---------------- driver ----------------
    // Inputs change on the falling edge; results are sampled 1 ns after the next rising
    // edge, which is valid for both the combinational and the registered build.
    task automatic apply(input logic [15:0] x1, input logic [15:0] x2, input logic [3:0] o,
                         input logic n1, input logic n2);
        @(negedge clk);
        in1  = x1;
        in2  = x2;
        op   = o;
        neg1 = n1;
        neg2 = n2;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_out, input logic e_c);
        check({tag, ".out"}, 32'(out), 32'(e_out));
        check({tag, ".cOut"}, 32'(cOut), 32'(e_c));
        check({tag, ".zero"}, 32'(zero), 32'(e_out == 16'h0));
        check({tag, ".gZero"}, 32'(gZero), 32'(e_out != 16'h0 && !e_out[15]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [16:0] exp_v;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [3:0]  ro;
        logic        rn1;
        logic        rn2;

        rst  = 1'b0;
        in1  = 16'h1234;
        in2  = 16'h0001;
        op   = 4'b0100;
        neg1 = 1'b0;
        neg2 = 1'b0;
        #12;
`ifdef ALU_OUT_REG_EN
        check_all("reset", 16'h0000, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;

        apply(16'h0000, 16'h0000, 4'b0100, 1'b0, 1'b0);
        check_all("add_zero", 16'h0000, 1'b0);

        apply(16'h8001, 16'h0004, 4'b0010, 1'b0, 1'b0);
        check_all("rol4", 16'h0018, 1'b0);
        apply(16'h8001, 16'h0004, 4'b0011, 1'b0, 1'b0);
        check_all("ror4", 16'h1800, 1'b0);
        apply(16'h8001, 16'h0010, 4'b0010, 1'b0, 1'b0);
        check_all("rol0", 16'h8001, 1'b0);
        apply(16'h8001, 16'h0010, 4'b0011, 1'b0, 1'b0);
        check_all("ror0", 16'h8001, 1'b0);

        apply(16'hFFFF, 16'h0001, 4'b0100, 1'b0, 1'b0);
        check_all("add_ovf", 16'h0000, 1'b1);

        apply(16'd5, 16'd3, 4'b0100, 1'b1, 1'b0);
        check_all("neg1_add", 16'hFFFE, 1'b0);
        apply(16'd5, 16'd3, 4'b0100, 1'b0, 1'b1);
        check_all("neg2_add", 16'h0001, 1'b1);

        apply(16'h0001, 16'h0000, 4'b1011, 1'b0, 1'b0);
        check_all("rev", 16'h8000, 1'b0);
        apply(16'h12AB, 16'h34CD, 4'b1100, 1'b0, 1'b0);
        check_all("pack_c", 16'hABCD, 1'b0);
        apply(16'h12AB, 16'h34CD, 4'b1111, 1'b0, 1'b0);
        check_all("pack_f", 16'hABCD, 1'b0);

        apply(16'h8421, 16'h0003, 4'b0000, 1'b0, 1'b0);
        check_all("sll3", 16'h2108, 1'b0);
        apply(16'h8421, 16'h0003, 4'b0001, 1'b0, 1'b0);
        check_all("srl3", 16'h1084, 1'b0);

        // Randomized sweep over all ops and conditioning combinations.
        for (int k = 0; k < 400; k++) begin
            r1  = 16'($urandom);
            r2  = 16'($urandom);
            ro  = 4'($urandom_range(0, 15));
            rn1 = 1'($urandom_range(0, 1));
            rn2 = 1'($urandom_range(0, 1));
            if (k % 25 == 0) r1 = 16'h0000;
            apply(r1, r2, ro, rn1, rn2);
            exp_v = model(r1, r2, ro, rn1, rn2);
            check_all($sformatf("rnd%0d_op%0d", k, ro), exp_v[15:0], exp_v[16]);
        end

`ifdef ALU_OUT_REG_EN
        // Async reset asserted mid-cycle takes effect without a clock edge.
        apply(16'h7000, 16'h0001, 4'b0111, 1'b0, 1'b0);
        check_all("pre_rst", 16'h7001, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 1'b0);
        @(negedge clk);
        rst  = 1'b1;
        in1  = 16'h0100;
        in2  = 16'h0001;
        op   = 4'b0000;
        neg1 = 1'b0;
        neg2 = 1'b0;
        #1;
        check_all("hold_before_edge", 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check_all("first_after_rel", 16'h0200, 1'b0);
        @(negedge clk);
        in1 = 16'hFFFF;
        op  = 4'b0100;
        #1;
        check_all("latency_old", 16'h0200, 1'b0);
        @(posedge clk);
        #1;
        check_all("latency_new", 16'h0000, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
